// File: rtl/sonic_v1_15_eth_10g_pause_req_gen_if.sv
// ---------------------------------------------------------------------------
// sonic_v1_15_eth_10g_pause_req_gen_if
//
// Pause-frame request channel between the pause request generator and the
// 10G TX pause-frame inserter / arbiter. Avalon-ST style valid/ready: a
// request is accepted on any cycle where tx_req_valid && tx_req_ready.
//
// Signals:
//   tx_req_valid    request valid (generator -> arbiter)
//   tx_req_ready    arbiter accepts request (arbiter -> generator)
//   tx_req_quanta   pause quanta to place in the frame
//   tx_req_is_xoff  1 = XOFF frame, 0 = XON frame (quanta 0)
//
// Modports:
//   master  the request generator
//   slave   the TX arbiter
// ---------------------------------------------------------------------------
interface sonic_v1_15_eth_10g_pause_req_gen_if #(
  parameter int QW = 16
);
  logic          tx_req_valid;
  logic          tx_req_ready;
  logic [QW-1:0] tx_req_quanta;
  logic          tx_req_is_xoff;

  modport master (
    output tx_req_valid,
    output tx_req_quanta,
    output tx_req_is_xoff,
    input  tx_req_ready
  );

  modport slave (
    input  tx_req_valid,
    input  tx_req_quanta,
    input  tx_req_is_xoff,
    output tx_req_ready
  );
endinterface

// File: rtl/sonic_v1_15_eth_10g_pause_req_gen.sv
// ---------------------------------------------------------------------------
// sonic_v1_15_eth_10g_pause_req_gen
//
// Turns the 2-bit pause-control level coming from the pause-generator timing
// adapter into discrete pause-frame requests for the 10G TX arbiter.
//   - XOFF desired (pause_ctrl[1]) while idle -> one XOFF request.
//   - While the peer is held off, the XOFF is re-sent every cfg_refresh
//     cycles as long as XOFF is still asked for.
//   - XON desired (2'b01) or block disabled while holding -> one XON request
//     with quanta 0.
//   - If the command goes quiet (2'b00) while holding, the block drops back
//     to idle at the next refresh expiry without sending XON; the peer's
//     pause quanta simply times out.
// Accepted XOFF/XON requests are counted in saturating statistics.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   pause_ctrl     2'b1x XOFF, 2'b01 XON, 2'b00 no new command
//   cfg_enable     block enable
//   cfg_quanta     quanta placed in XOFF frames (captured per request)
//   cfg_refresh    XOFF refresh period in cycles, 0 = no refresh
//   tx_req         request channel (master side), see the interface file
//   xoff_active    peer currently held paused by this block
//   stat_xoff_cnt  accepted XOFF requests, saturating
//   stat_xon_cnt   accepted XON requests, saturating
// ---------------------------------------------------------------------------
module sonic_v1_15_eth_10g_pause_req_gen #(
  parameter int QW     = 16,
  parameter int STAT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           pause_ctrl,
  input  logic                 cfg_enable,
  input  logic [QW-1:0]        cfg_quanta,
  input  logic [QW-1:0]        cfg_refresh,
  sonic_v1_15_eth_10g_pause_req_gen_if.master tx_req,
  output logic                 xoff_active,
  output logic [STAT_W-1:0]    stat_xoff_cnt,
  output logic [STAT_W-1:0]    stat_xon_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XOFF_REQ  = 2'd1,
    XOFF_HOLD = 2'd2,
    XON_REQ   = 2'd3
  } state_t;

  state_t        state;
  logic [QW-1:0] refresh_cnt;
  // Refresh enable is captured with the period at XOFF acceptance, so a
  // cfg_refresh change mid-period only affects the next period.
  logic          refresh_on;
  logic          handshake;
  logic          xon_wanted;
  logic          refresh_expired;

  assign handshake       = tx_req.tx_req_valid && tx_req.tx_req_ready;
  // XOFF wins over XON, so only the exact 2'b01 encoding asks for release.
  assign xon_wanted      = (pause_ctrl == 2'b01) || !cfg_enable;
  assign refresh_expired = refresh_on && (refresh_cnt <= QW'(1));

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  // Request outputs are registered and only change on state entry or on
  // acceptance, which keeps valid/quanta/is_xoff stable under backpressure
  // whatever pause_ctrl, cfg_enable or cfg_quanta do in the meantime.
  //
  // Refresh timing: the counter is loaded with cfg_refresh-1 on the edge
  // that accepts the XOFF, then counts down once per XOFF_HOLD edge; the
  // edge that sees it at 1 re-raises valid, which lands exactly cfg_refresh
  // cycles after the accepting cycle.
  //
  // NOTE: the reset branch lives inside the clocked block, so it is sampled
  // on the clock edge only; every state register is cleared there and no
  // handshake side effect (stat increment) can happen on a reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      tx_req.tx_req_valid   <= 1'b0;
      tx_req.tx_req_quanta  <= '0;
      tx_req.tx_req_is_xoff <= 1'b0;
      xoff_active           <= 1'b0;
      refresh_cnt           <= '0;
      refresh_on            <= 1'b0;
      stat_xoff_cnt         <= '0;
      stat_xon_cnt          <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of state, counters and outputs.
      case (state)
        IDLE: begin
          // XON / no-command levels mean nothing while nothing is held.
          if (cfg_enable && pause_ctrl[1]) begin
            state                 <= XOFF_REQ;
            tx_req.tx_req_valid   <= 1'b1;
            tx_req.tx_req_is_xoff <= 1'b1;
            tx_req.tx_req_quanta  <= cfg_quanta;
          end
        end

        XOFF_REQ: begin
          if (handshake) begin
            state               <= XOFF_HOLD;
            tx_req.tx_req_valid <= 1'b0;
            xoff_active         <= 1'b1;
            stat_xoff_cnt       <= sat_inc(stat_xoff_cnt);
            refresh_on          <= (cfg_refresh != '0);
            refresh_cnt         <= (cfg_refresh != '0) ? cfg_refresh - QW'(1) : '0;
          end
        end

        XOFF_HOLD: begin
          if (xon_wanted) begin
            state                 <= XON_REQ;
            tx_req.tx_req_valid   <= 1'b1;
            tx_req.tx_req_is_xoff <= 1'b0;
            tx_req.tx_req_quanta  <= '0;
          end else if (refresh_expired) begin
            if (pause_ctrl[1]) begin
              // Still asked to hold: re-send XOFF with the current quanta.
              state                 <= XOFF_REQ;
              tx_req.tx_req_valid   <= 1'b1;
              tx_req.tx_req_is_xoff <= 1'b1;
              tx_req.tx_req_quanta  <= cfg_quanta;
            end else begin
              // Command went quiet: let the peer's quanta time out.
              state       <= IDLE;
              xoff_active <= 1'b0;
              refresh_on  <= 1'b0;
            end
          end else if (refresh_on) begin
            refresh_cnt <= refresh_cnt - QW'(1);
          end
        end

        XON_REQ: begin
          if (handshake) begin
            state               <= IDLE;
            tx_req.tx_req_valid <= 1'b0;
            xoff_active         <= 1'b0;
            refresh_on          <= 1'b0;
            stat_xon_cnt        <= sat_inc(stat_xon_cnt);
          end
        end

        default: begin
          state               <= IDLE;
          tx_req.tx_req_valid <= 1'b0;
          xoff_active         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_v1_15_eth_10g_pause_req_gen.sv
// ---------------------------------------------------------------------------
// Testbench for sonic_v1_15_eth_10g_pause_req_gen.
// Inputs change just after a falling edge; outputs are sampled on falling
// edges. A second instance with 4-bit statistics shares all stimulus so
// counter saturation can be reached in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_sonic_v1_15_eth_10g_pause_req_gen;

  localparam int QW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    pause_ctrl;
  logic          cfg_enable;
  logic [QW-1:0] cfg_quanta;
  logic [QW-1:0] cfg_refresh;
  logic          xoff_active;
  logic [15:0]   stat_xoff_cnt;
  logic [15:0]   stat_xon_cnt;
  logic          s_xoff_active;
  logic [3:0]    s_xoff_cnt;
  logic [3:0]    s_xon_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_xoff = 0;
  int exp_xon  = 0;

  sonic_v1_15_eth_10g_pause_req_gen_if #(.QW(QW)) tx_req ();
  sonic_v1_15_eth_10g_pause_req_gen_if #(.QW(QW)) tx_req_s ();

  assign tx_req_s.tx_req_ready = tx_req.tx_req_ready;

  sonic_v1_15_eth_10g_pause_req_gen #(.QW(QW), .STAT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pause_ctrl    (pause_ctrl),
    .cfg_enable    (cfg_enable),
    .cfg_quanta    (cfg_quanta),
    .cfg_refresh   (cfg_refresh),
    .tx_req        (tx_req.master),
    .xoff_active   (xoff_active),
    .stat_xoff_cnt (stat_xoff_cnt),
    .stat_xon_cnt  (stat_xon_cnt)
  );

  sonic_v1_15_eth_10g_pause_req_gen #(.QW(QW), .STAT_W(4)) dut_small (
    .clk           (clk),
    .reset         (reset),
    .pause_ctrl    (pause_ctrl),
    .cfg_enable    (cfg_enable),
    .cfg_quanta    (cfg_quanta),
    .cfg_refresh   (cfg_refresh),
    .tx_req        (tx_req_s.master),
    .xoff_active   (s_xoff_active),
    .stat_xoff_cnt (s_xoff_cnt),
    .stat_xon_cnt  (s_xon_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pause_ctrl = 2'b00; cfg_enable = 1'b1;
    cfg_quanta = 16'h0000; cfg_refresh = 16'd0; tx_req.tx_req_ready = 1'b0;
    step(); step();
    checks++; if (tx_req.tx_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", tx_req.tx_req_valid); end
    checks++; if (tx_req.tx_req_quanta !== 16'h0000) begin failures++; $display("FAIL reset_quanta: got %h want 0000", tx_req.tx_req_quanta); end
    checks++; if (tx_req.tx_req_is_xoff !== 1'b0) begin failures++; $display("FAIL reset_is_xoff: got %0b want 0", tx_req.tx_req_is_xoff); end
    checks++; if (xoff_active !== 1'b0) begin failures++; $display("FAIL reset_xoff_active: got %0b want 0", xoff_active); end
    checks++; if (stat_xoff_cnt !== 16'd0 || stat_xon_cnt !== 16'd0) begin failures++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_xoff_cnt, stat_xon_cnt); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_idle_ignore();
    logic seen;
    seen = 1'b0;
    tx_req.tx_req_ready = 1'b1;
    pause_ctrl = 2'b01;
    for (int i = 0; i < 3; i++) begin step(); if (tx_req.tx_req_valid !== 1'b0) seen = 1'b1; end
    cfg_enable = 1'b0; pause_ctrl = 2'b10;
    for (int i = 0; i < 3; i++) begin step(); if (tx_req.tx_req_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL idle_ignore: got valid=1 want 0 for XON-in-idle / disabled XOFF"); end
    cfg_enable = 1'b1; pause_ctrl = 2'b00;
    step();
  endtask

  task automatic test_basic();
    cfg_quanta = 16'h1234; cfg_refresh = 16'd0; tx_req.tx_req_ready = 1'b1;
    pause_ctrl = 2'b10;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1) begin failures++; $display("FAIL basic_xoff_valid: got %0b want 1", tx_req.tx_req_valid); end
    checks++; if (tx_req.tx_req_is_xoff !== 1'b1) begin failures++; $display("FAIL basic_xoff_is_xoff: got %0b want 1", tx_req.tx_req_is_xoff); end
    checks++; if (tx_req.tx_req_quanta !== 16'h1234) begin failures++; $display("FAIL basic_xoff_quanta: got %h want 1234", tx_req.tx_req_quanta); end
    pause_ctrl = 2'b00;
    step(); exp_xoff++;
    checks++; if (tx_req.tx_req_valid !== 1'b0) begin failures++; $display("FAIL basic_after_xoff_valid: got %0b want 0", tx_req.tx_req_valid); end
    checks++; if (xoff_active !== 1'b1) begin failures++; $display("FAIL basic_xoff_active: got %0b want 1", xoff_active); end
    checks++; if (stat_xoff_cnt !== 16'(exp_xoff)) begin failures++; $display("FAIL basic_stat_xoff: got %0d want %0d", stat_xoff_cnt, exp_xoff); end
    step(); step(); step();
    checks++; if (tx_req.tx_req_valid !== 1'b0 || xoff_active !== 1'b1) begin failures++; $display("FAIL basic_hold_no_refresh: got valid=%0b active=%0b want 0/1", tx_req.tx_req_valid, xoff_active); end
    pause_ctrl = 2'b01;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1 || tx_req.tx_req_is_xoff !== 1'b0 || tx_req.tx_req_quanta !== 16'h0000) begin
      failures++; $display("FAIL basic_xon_req: got valid=%0b is_xoff=%0b quanta=%h want 1/0/0000", tx_req.tx_req_valid, tx_req.tx_req_is_xoff, tx_req.tx_req_quanta); end
    pause_ctrl = 2'b00;
    step(); exp_xon++;
    checks++; if (tx_req.tx_req_valid !== 1'b0 || xoff_active !== 1'b0) begin failures++; $display("FAIL basic_after_xon: got valid=%0b active=%0b want 0/0", tx_req.tx_req_valid, xoff_active); end
    checks++; if (stat_xon_cnt !== 16'(exp_xon) || stat_xoff_cnt !== 16'(exp_xoff)) begin failures++; $display("FAIL basic_stats: got %0d/%0d want %0d/%0d", stat_xoff_cnt, stat_xon_cnt, exp_xoff, exp_xon); end
  endtask

  task automatic test_backpressure();
    logic [1:0] pc_seq [4];
    pc_seq[0] = 2'b01; pc_seq[1] = 2'b11; pc_seq[2] = 2'b00; pc_seq[3] = 2'b01;
    cfg_quanta = 16'h0042; tx_req.tx_req_ready = 1'b0;
    pause_ctrl = 2'b10;
    step();
    for (int i = 0; i < 20; i++) begin
      pause_ctrl = pc_seq[i % 4];
      cfg_quanta = 16'hBEEF + 16'(i);
      cfg_enable = (i % 3 != 1);
      step();
      checks++; if (tx_req.tx_req_valid !== 1'b1 || tx_req.tx_req_is_xoff !== 1'b1 || tx_req.tx_req_quanta !== 16'h0042) begin
        failures++; $display("FAIL bp_stable[%0d]: got valid=%0b is_xoff=%0b quanta=%h want 1/1/0042", i, tx_req.tx_req_valid, tx_req.tx_req_is_xoff, tx_req.tx_req_quanta); end
    end
    cfg_enable = 1'b1; pause_ctrl = 2'b01; tx_req.tx_req_ready = 1'b1;
    step(); exp_xoff++;
    checks++; if (tx_req.tx_req_valid !== 1'b0 || xoff_active !== 1'b1 || stat_xoff_cnt !== 16'(exp_xoff)) begin
      failures++; $display("FAIL bp_accept: got valid=%0b active=%0b xoff_cnt=%0d want 0/1/%0d", tx_req.tx_req_valid, xoff_active, stat_xoff_cnt, exp_xoff); end
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1 || tx_req.tx_req_is_xoff !== 1'b0 || tx_req.tx_req_quanta !== 16'h0000) begin
      failures++; $display("FAIL bp_xon: got valid=%0b is_xoff=%0b quanta=%h want 1/0/0000", tx_req.tx_req_valid, tx_req.tx_req_is_xoff, tx_req.tx_req_quanta); end
    pause_ctrl = 2'b00;
    step(); exp_xon++;
    checks++; if (xoff_active !== 1'b0 || stat_xon_cnt !== 16'(exp_xon)) begin failures++; $display("FAIL bp_after_xon: got active=%0b xon_cnt=%0d want 0/%0d", xoff_active, stat_xon_cnt, exp_xon); end
  endtask

  task automatic test_refresh();
    int t [8];
    int n;
    n = 0;
    cfg_quanta = 16'h0100; cfg_refresh = 16'd100; tx_req.tx_req_ready = 1'b1;
    pause_ctrl = 2'b10;
    for (int i = 0; i < 500; i++) begin
      step();
      if (tx_req.tx_req_valid === 1'b1) begin
        if (n < 8) t[n] = i;
        n++;
        checks++; if (tx_req.tx_req_is_xoff !== 1'b1 || tx_req.tx_req_quanta !== 16'h0100) begin
          failures++; $display("FAIL refresh_req_fields@%0d: got is_xoff=%0b quanta=%h want 1/0100", i, tx_req.tx_req_is_xoff, tx_req.tx_req_quanta); end
      end
    end
    exp_xoff += 5;
    checks++; if (n != 5) begin failures++; $display("FAIL refresh_count: got %0d requests want 5", n); end
    checks++; if (n >= 1 && t[0] != 0) begin failures++; $display("FAIL refresh_first_latency: got cycle %0d want 0", t[0]); end
    for (int k = 1; k < 5 && k < n; k++) begin
      checks++; if (t[k] - t[k-1] != 100) begin failures++; $display("FAIL refresh_period[%0d]: got %0d want 100", k, t[k] - t[k-1]); end
    end
    checks++; if (stat_xoff_cnt !== 16'(exp_xoff)) begin failures++; $display("FAIL refresh_stat_xoff: got %0d want %0d", stat_xoff_cnt, exp_xoff); end
    pause_ctrl = 2'b01;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1 || tx_req.tx_req_is_xoff !== 1'b0) begin failures++; $display("FAIL refresh_release_xon: got valid=%0b is_xoff=%0b want 1/0", tx_req.tx_req_valid, tx_req.tx_req_is_xoff); end
    pause_ctrl = 2'b00;
    step(); exp_xon++;
  endtask

  task automatic test_silent_release();
    logic seen;
    seen = 1'b0;
    cfg_refresh = 16'd50; tx_req.tx_req_ready = 1'b1;
    pause_ctrl = 2'b10;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1) begin failures++; $display("FAIL silent_xoff_valid: got %0b want 1", tx_req.tx_req_valid); end
    pause_ctrl = 2'b00;
    exp_xoff++;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (tx_req.tx_req_valid !== 1'b0) seen = 1'b1;
      if (i == 49) begin
        checks++; if (xoff_active !== 1'b1) begin failures++; $display("FAIL silent_active_before_expiry: got %0b want 1", xoff_active); end
      end
      if (i == 50) begin
        checks++; if (xoff_active !== 1'b0) begin failures++; $display("FAIL silent_active_at_expiry: got %0b want 0", xoff_active); end
      end
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL silent_no_request: got a request want none"); end
    checks++; if (stat_xon_cnt !== 16'(exp_xon) || stat_xoff_cnt !== 16'(exp_xoff)) begin failures++; $display("FAIL silent_stats: got %0d/%0d want %0d/%0d", stat_xoff_cnt, stat_xon_cnt, exp_xoff, exp_xon); end
  endtask

  task automatic test_disable();
    cfg_refresh = 16'd0; cfg_quanta = 16'h0777; tx_req.tx_req_ready = 1'b1;
    pause_ctrl = 2'b11;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1 || tx_req.tx_req_is_xoff !== 1'b1 || tx_req.tx_req_quanta !== 16'h0777) begin
      failures++; $display("FAIL dis_11_is_xoff: got valid=%0b is_xoff=%0b quanta=%h want 1/1/0777", tx_req.tx_req_valid, tx_req.tx_req_is_xoff, tx_req.tx_req_quanta); end
    pause_ctrl = 2'b00;
    step(); exp_xoff++;
    checks++; if (xoff_active !== 1'b1) begin failures++; $display("FAIL dis_hold_active: got %0b want 1", xoff_active); end
    cfg_enable = 1'b0;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1 || tx_req.tx_req_is_xoff !== 1'b0 || tx_req.tx_req_quanta !== 16'h0000) begin
      failures++; $display("FAIL dis_xon: got valid=%0b is_xoff=%0b quanta=%h want 1/0/0000", tx_req.tx_req_valid, tx_req.tx_req_is_xoff, tx_req.tx_req_quanta); end
    step(); exp_xon++;
    checks++; if (xoff_active !== 1'b0 || stat_xon_cnt !== 16'(exp_xon)) begin failures++; $display("FAIL dis_after_xon: got active=%0b xon_cnt=%0d want 0/%0d", xoff_active, stat_xon_cnt, exp_xon); end
    cfg_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    tx_req.tx_req_ready = 1'b0; cfg_quanta = 16'h5555;
    pause_ctrl = 2'b10;
    step();
    checks++; if (tx_req.tx_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending: got %0b want 1", tx_req.tx_req_valid); end
    reset = 1'b1; tx_req.tx_req_ready = 1'b1;
    step();
    exp_xoff = 0; exp_xon = 0;
    checks++; if (tx_req.tx_req_valid !== 1'b0 || tx_req.tx_req_quanta !== 16'h0000 || tx_req.tx_req_is_xoff !== 1'b0) begin
      failures++; $display("FAIL rstmid_req: got valid=%0b quanta=%h is_xoff=%0b want 0/0000/0", tx_req.tx_req_valid, tx_req.tx_req_quanta, tx_req.tx_req_is_xoff); end
    checks++; if (stat_xoff_cnt !== 16'd0 || stat_xon_cnt !== 16'd0 || xoff_active !== 1'b0) begin
      failures++; $display("FAIL rstmid_state: got xoff=%0d xon=%0d active=%0b want 0/0/0", stat_xoff_cnt, stat_xon_cnt, xoff_active); end
    checks++; if (s_xoff_cnt !== 4'd0 || s_xon_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_small_stats: got %0d/%0d want 0/0", s_xoff_cnt, s_xon_cnt); end
    reset = 1'b0; tx_req.tx_req_ready = 1'b0; pause_ctrl = 2'b00;
    step();
  endtask

  task automatic test_saturation();
    logic [3:0] exp_s;
    cfg_refresh = 16'd2; cfg_quanta = 16'h0009; tx_req.tx_req_ready = 1'b1;
    pause_ctrl = 2'b10;
    for (int i = 0; i < 80; i++) step();
    exp_xoff += 40;
    exp_s = (exp_xoff > 15) ? 4'hF : exp_xoff[3:0];
    checks++; if (stat_xoff_cnt !== 16'(exp_xoff)) begin failures++; $display("FAIL sat_wide_xoff: got %0d want %0d", stat_xoff_cnt, exp_xoff); end
    checks++; if (s_xoff_cnt !== exp_s) begin failures++; $display("FAIL sat_small_xoff: got %0d want %0d", s_xoff_cnt, exp_s); end
    pause_ctrl = 2'b01;
    step();
    pause_ctrl = 2'b00;
    step(); exp_xon++;
    checks++; if (s_xoff_cnt !== 4'hF || s_xon_cnt !== 4'(exp_xon)) begin failures++; $display("FAIL sat_small_hold: got %0d/%0d want 15/%0d", s_xoff_cnt, s_xon_cnt, exp_xon); end
    checks++; if (stat_xon_cnt !== 16'(exp_xon) || xoff_active !== 1'b0) begin failures++; $display("FAIL sat_release: got xon=%0d active=%0b want %0d/0", stat_xon_cnt, xoff_active, exp_xon); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_backpressure();
    test_refresh();
    test_silent_release();
    test_disable();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sonic_v1_15_eth_10g_pause_req_gen.md
Name: sonic_v1_15_eth_10g_pause_req_gen

Overview:
Consumes the 2-bit pause-control level from the pause-generator timing adapter (out_data) and converts it into discrete pause-frame transmit requests for the 10G TX arbiter. Issues XOFF requests, with periodic refresh while XOFF stays asserted, and an XON (quanta 0) request on release. Sits between the pause-control timing adapter and the TX pause-frame inserter. Provides Avalon-ST-style valid/ready on the request side and saturating statistics.

Parameters:
QW, 16, width of pause quanta and refresh counter
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pause_ctrl  in  2  from timing adapter: 2'b1x = XOFF desired, 2'b01 = XON desired, 2'b00 = no new command
cfg_enable  in  1  block enable
cfg_quanta  in  QW  quanta placed in XOFF frames
cfg_refresh  in  QW  XOFF refresh period in cycles; 0 = no refresh
tx_req_valid  out  1  pause frame request valid
tx_req_ready  in  1  arbiter accepts request
tx_req_quanta  out  QW  quanta for requested frame
tx_req_is_xoff  out  1  1 = XOFF frame, 0 = XON frame
xoff_active  out  1  peer currently held paused by this block
stat_xoff_cnt  out  STAT_W  accepted XOFF requests, saturating
stat_xon_cnt  out  STAT_W  accepted XON requests, saturating

Behaviour:
- Reset values: state IDLE; tx_req_valid 0; tx_req_quanta 0; tx_req_is_xoff 0; xoff_active 0; refresh counter 0; both stat counters 0.
- All outputs are registered. Handshake occurs on a cycle where tx_req_valid && tx_req_ready.
- States:
  - IDLE: if cfg_enable && pause_ctrl[1], go to XOFF_REQ. tx_req_valid rises the cycle after pause_ctrl is sampled (1-cycle latency). pause_ctrl 01/00 are ignored in IDLE.
  - XOFF_REQ:
    - tx_req_valid=1, tx_req_is_xoff=1, tx_req_quanta = cfg_quanta captured on entry.
    - On handshake: go to XOFF_HOLD, set xoff_active=1, increment stat_xoff_cnt, load refresh counter.
  - XOFF_HOLD (tx_req_valid=0). Priority order:
    - If pause_ctrl==01 or !cfg_enable, go to XON_REQ.
    - Else if cfg_refresh!=0 and the counter expires:
      - pause_ctrl[1]=1: go to XOFF_REQ (refresh).
      - pause_ctrl==00: go to IDLE with xoff_active=0, no XON sent; peer quanta is left to time out.
    - cfg_refresh==0: stay in XOFF_HOLD until XON or disable.
  - XON_REQ:
    - tx_req_valid=1, tx_req_is_xoff=0, tx_req_quanta=0.
    - On handshake: go to IDLE, set xoff_active=0, increment stat_xon_cnt.
- Refresh timing: for cfg_refresh>=2, tx_req_valid reasserts exactly cfg_refresh cycles after the XOFF handshake cycle. cfg_refresh is sampled at the handshake; later changes apply to the next period.
- Request stability: once tx_req_valid=1, valid, quanta and is_xoff hold unchanged until handshake, regardless of pause_ctrl, cfg_enable or cfg_quanta changes. Any command change is evaluated after acceptance.
- pause_ctrl=2'b11 is treated as XOFF (XOFF wins).
- Stat counters saturate at all-ones and do not wrap.
- Reset asserted mid-request: tx_req_valid is 0 the cycle after reset is sampled, and all state returns to reset values. No handshake is counted on the reset cycle.
- tx_req_ready asserted while tx_req_valid=0 has no effect.

Test Plan:
- Basic XOFF/XON: cfg_quanta=0x1234, cfg_refresh=0, ready=1; pause_ctrl 00→10 at cycle 10 → valid=1, is_xoff=1, quanta=0x1234 at cycle 11; then pause_ctrl→01 → one XON with quanta=0; stat_xoff_cnt=1, stat_xon_cnt=1, xoff_active back to 0.
- Backpressure stability: ready=0 for 20 cycles while XOFF is pending and pause_ctrl toggles to 01 and cfg_quanta changes → valid, quanta and is_xoff stay constant; after ready, XON follows.
- Refresh: cfg_refresh=100, pause_ctrl held 10, ready=1 → XOFF handshakes exactly every 100 cycles; stat_xoff_cnt=5 after 5 periods.
- Silent release: in XOFF_HOLD, pause_ctrl→00 with cfg_refresh=50 → no XON issued; state returns to IDLE at expiry and xoff_active drops.
- Disable and reset: cfg_enable dropped in XOFF_HOLD → XON issued. Reset asserted while tx_req_valid=1, ready=0 → valid=0 next cycle and all counters 0.
- Saturation: preload via 0xFFFF XOFF handshakes (STAT_W=16), then one more → stat_xoff_cnt stays 0xFFFF.
